// File: rtl/scratchpad_bank_arbiter_if.sv
// Bus bundle between the scratchpad bank arbiter, its requesters and one SRAM bank.
// The slave modport is the arbiter's view; the master modport is the view of the
// environment (requesting engines plus the bank) that drives the arbiter.
interface scratchpad_bank_arbiter_if #(
    parameter int NREQ     = 4,
    parameter int ADDRBITS = 9
);
    // Requester side
    logic [NREQ*ADDRBITS-1:0] req_addr;
    logic [NREQ-1:0]          req_ren;
    logic [NREQ-1:0]          req_wen;
    logic [NREQ*32-1:0]       req_wdata;
    logic [NREQ-1:0]          req_gnt;
    logic [NREQ-1:0]          req_rvalid;
    logic [31:0]              req_rdata;
    logic [NREQ-1:0]          req_err;
    logic                     busy;

    // Bank side
    logic [ADDRBITS-1:0]      bank_addr;
    logic                     bank_ren;
    logic                     bank_wen;
    logic [31:0]              bank_wdata;
    logic [31:0]              bank_rdata;
    logic                     bank_rvalid;

    modport slave (
        input  req_addr, req_ren, req_wen, req_wdata, bank_rdata, bank_rvalid,
        output req_gnt, req_rvalid, req_rdata, req_err, busy,
               bank_addr, bank_ren, bank_wen, bank_wdata
    );

    modport master (
        output req_addr, req_ren, req_wen, req_wdata, bank_rdata, bank_rvalid,
        input  req_gnt, req_rvalid, req_rdata, req_err, busy,
               bank_addr, bank_ren, bank_wen, bank_wdata
    );
endinterface

// File: rtl/scratchpad_bank_arbiter.sv
// Round-robin arbiter sharing one scratchpad SRAM bank between NREQ requesters.
// Writes retire on their grant cycle; a read holds the bank (RD_WAIT) until the bank
// returns bank_rvalid, whose data is passed straight through to the owning requester.
// Optional feature macro: SCRATCHPAD_ARB_TIMEOUT_EN -- bounds the read wait to
// TIMEOUT_CYCLES silent cycles and then answers the owner with an error and 0xDEADBEEF.
module scratchpad_bank_arbiter #(
    parameter int NREQ           = 4,
    parameter int ADDRBITS       = 9,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    scratchpad_bank_arbiter_if.slave       bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;

    logic [NREQ-1:0]   cand;
    logic [PTR_W-1:0]  scan;
    logic [PTR_W-1:0]  winner;
    logic              found;

    logic [ADDRBITS-1:0] sel_addr;
    logic [31:0]         sel_wdata;
    logic                sel_ren;
    logic                sel_wen;
    logic [NREQ-1:0]     owner_oh;

    logic                timeout;

    // Round-robin search: first requesting index starting at rr_ptr, wrapping mod NREQ
    always_comb begin
        found  = 1'b0;
        winner = '0;
        scan   = '0;
        cand   = bus.req_ren | bus.req_wen;
        for (int k = 0; k < NREQ; k++) begin
            scan = PTR_W'((int'(rr_ptr_q) + k) % NREQ);
            if (!found && cand[scan]) begin
                found  = 1'b1;
                winner = scan;
            end
        end
    end

    // Route the winning requester's fields and decode the owner into a one-hot vector
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_ren   = 1'b0;
        sel_wen   = 1'b0;
        owner_oh  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == PTR_W'(i)) begin
                sel_addr  = bus.req_addr[i*ADDRBITS +: ADDRBITS];
                sel_wdata = bus.req_wdata[i*32 +: 32];
                sel_ren   = bus.req_ren[i];
                sel_wen   = bus.req_wen[i];
            end
            owner_oh[i] = (owner_q == PTR_W'(i));
        end
    end

`ifdef SCRATCHPAD_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;

    assign timeout = (state_q == RD_WAIT) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

    // Count silent RD_WAIT cycles; restart from zero whenever a read is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (state_q == IDLE && state_d == RD_WAIT) begin
            to_cnt_q <= '0;
        end else if (state_q == RD_WAIT && !bus.bank_rvalid && !timeout) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    // Without the timeout feature a read waits for the bank indefinitely.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    // Control state: FSM state, round-robin pointer and read owner
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    // Next state and all bus outputs; everything is forced low while rst is high
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        bus.req_gnt    = '0;
        bus.req_rvalid = '0;
        bus.req_rdata  = '0;
        bus.req_err    = '0;
        bus.busy       = 1'b0;
        bus.bank_addr  = '0;
        bus.bank_ren   = 1'b0;
        bus.bank_wen   = 1'b0;
        bus.bank_wdata = '0;

        case (state_q)
            IDLE: begin
                // bank_rvalid seen here is spurious and deliberately ignored
                if (found) begin
                    bus.req_gnt[winner] = 1'b1;
                    bus.bank_addr       = sel_addr;
                    bus.bank_wdata      = sel_wdata;
                    bus.bank_wen        = sel_wen;
                    // A simultaneous ren+wen is treated as a write
                    bus.bank_ren        = sel_ren & ~sel_wen;
                    rr_ptr_d = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
                    if (!sel_wen) begin
                        owner_d = winner;
                        state_d = RD_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                bus.busy = 1'b1;
                if (bus.bank_rvalid) begin
                    // Real data wins over a timeout landing in the same cycle
                    bus.req_rvalid = owner_oh;
                    bus.req_rdata  = bus.bank_rdata;
                    state_d        = IDLE;
                end else if (timeout) begin
                    bus.req_rvalid = owner_oh;
                    bus.req_err    = owner_oh;
                    bus.req_rdata  = TIMEOUT_DATA;
                    state_d        = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            bus.req_gnt    = '0;
            bus.req_rvalid = '0;
            bus.req_rdata  = '0;
            bus.req_err    = '0;
            bus.busy       = 1'b0;
            bus.bank_addr  = '0;
            bus.bank_ren   = 1'b0;
            bus.bank_wen   = 1'b0;
            bus.bank_wdata = '0;
        end
    end

endmodule

// File: tb/tb_scratchpad_bank_arbiter.sv
// Bench for scratchpad_bank_arbiter: a table of directed per-cycle vectors, a hand
// written long-read sequence (timeout or indefinite wait depending on
// SCRATCHPAD_ARB_TIMEOUT_EN), then randomized traffic against a reference model.
module tb_scratchpad_bank_arbiter;
    localparam int NREQ = 4;
    localparam int AB   = 9;
    localparam int TO   = 8;
`ifdef SCRATCHPAD_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scratchpad_bank_arbiter_if #(.NREQ(NREQ), .ADDRBITS(AB)) bus ();

    scratchpad_bank_arbiter #(
        .NREQ(NREQ), .ADDRBITS(AB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic [3:0]  gnt;
        logic        bwen;
        logic        bren;
        logic [8:0]  baddr;
        logic [31:0] bwdata;
        logic [3:0]  rvalid;
        logic [31:0] rdata;
        logic [3:0]  err;
        logic        busy;
    } exp_t;

    typedef struct packed {
        logic        r;
        logic [3:0]  ren;
        logic [3:0]  wen;
        logic        brv;
        logic [31:0] brd;
        exp_t        e;
    } vec_t;

    int tests = 0;
    int fails = 0;

    logic [8:0]  cur_addr [NREQ];
    logic [31:0] cur_wd   [NREQ];
    logic [8:0]  taddr    [NREQ];
    logic [31:0] twd      [NREQ];

    // reference model state
    int m_rr;
    int m_own;
    int m_wait;

    vec_t tv [32];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mke(input logic [3:0] gnt, input logic bwen, input logic bren,
                                 input int w, input logic [3:0] rv, input logic [31:0] rd,
                                 input logic [3:0] err, input logic busy);
        exp_t e;
        e = '0;
        e.gnt = gnt; e.bwen = bwen; e.bren = bren;
        if (w >= 0) begin
            e.baddr  = taddr[w];
            e.bwdata = twd[w];
        end
        e.rvalid = rv; e.rdata = rd; e.err = err; e.busy = busy;
        return e;
    endfunction

    function automatic vec_t mkv(input logic r, input logic [3:0] ren, input logic [3:0] wen,
                                 input logic brv, input logic [31:0] brd, input exp_t e);
        vec_t v;
        v.r = r; v.ren = ren; v.wen = wen; v.brv = brv; v.brd = brd; v.e = e;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [3:0] ren, input logic [3:0] wen,
                         input logic brv, input logic [31:0] brd);
        rst             = r;
        bus.req_ren     = ren;
        bus.req_wen     = wen;
        bus.bank_rvalid = brv;
        bus.bank_rdata  = brd;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AB +: AB] = cur_addr[i];
            bus.req_wdata[i*32 +: 32] = cur_wd[i];
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, ".gnt"},    64'(bus.req_gnt),    64'(e.gnt));
        chk({tag, ".bwen"},   64'(bus.bank_wen),   64'(e.bwen));
        chk({tag, ".bren"},   64'(bus.bank_ren),   64'(e.bren));
        chk({tag, ".baddr"},  64'(bus.bank_addr),  64'(e.baddr));
        chk({tag, ".bwdata"}, 64'(bus.bank_wdata), 64'(e.bwdata));
        chk({tag, ".rvalid"}, 64'(bus.req_rvalid), 64'(e.rvalid));
        chk({tag, ".rdata"},  64'(bus.req_rdata),  64'(e.rdata));
        chk({tag, ".err"},    64'(bus.req_err),    64'(e.err));
        chk({tag, ".busy"},   64'(bus.busy),       64'(e.busy));
    endtask

    // one cycle: drive just after the rising edge, compare on the falling edge
    task automatic cycle(input string tag, input logic r, input logic [3:0] ren,
                         input logic [3:0] wen, input logic brv, input logic [31:0] brd,
                         input exp_t e);
        drive(r, ren, wen, brv, brd);
        @(negedge clk);
        check_out(tag, e);
        @(posedge clk);
        #1;
    endtask

    // Reference model: round-robin from the pointer, reads own the bank until data or timeout
    task automatic model_step(input logic r, input logic [3:0] ren, input logic [3:0] wen,
                              input logic brv, input logic [31:0] brd, output exp_t e);
        e = '0;
        if (r) begin
            m_rr = 0; m_own = -1; m_wait = 0;
        end else if (m_own < 0) begin
            int w;
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_rr + k) % NREQ;
                if (w < 0 && (ren[j] || wen[j])) w = j;
            end
            if (w >= 0) begin
                e.gnt[w] = 1'b1;
                e.baddr  = cur_addr[w];
                e.bwdata = cur_wd[w];
                if (wen[w]) begin
                    e.bwen = 1'b1;
                end else begin
                    e.bren = 1'b1;
                    m_own  = w;
                    m_wait = 0;
                end
                m_rr = (w + 1) % NREQ;
            end
        end else begin
            e.busy = 1'b1;
            if (brv) begin
                e.rvalid[m_own] = 1'b1;
                e.rdata = brd;
                m_own = -1;
            end else if (TO_EN && m_wait == TO) begin
                e.rvalid[m_own] = 1'b1;
                e.err[m_own]    = 1'b1;
                e.rdata = 32'hDEAD_BEEF;
                m_own = -1;
            end else begin
                m_wait++;
            end
        end
    endtask

    initial begin
        exp_t e;
        logic r, brv;
        logic [3:0] ren, wen;
        logic [31:0] brd;

        taddr = '{9'h0F0, 9'h1A5, 9'h010, 9'h133};
        twd   = '{32'h1111_0000, 32'hCAFE_0001, 32'h2222_0002, 32'h3333_0003};
        for (int i = 0; i < NREQ; i++) begin
            cur_addr[i] = taddr[i];
            cur_wd[i]   = twd[i];
        end

        // reset hold with all reads asserted, then first grant to requester 0
        tv[0]  = mkv(1, 4'hF, 4'h0, 0, 0,            mke(4'h0, 0, 0, -1, 4'h0, 0, 4'h0, 0));
        tv[1]  = mkv(1, 4'hF, 4'h0, 0, 0,            mke(4'h0, 0, 0, -1, 4'h0, 0, 4'h0, 0));
        tv[2]  = mkv(1, 4'hF, 4'h0, 0, 0,            mke(4'h0, 0, 0, -1, 4'h0, 0, 4'h0, 0));
        tv[3]  = mkv(0, 4'hF, 4'h0, 0, 0,            mke(4'h1, 0, 1,  0, 4'h0, 0, 4'h0, 0));
        tv[4]  = mkv(0, 4'hF, 4'h0, 1, 32'hA5A5A5A5, mke(4'h0, 0, 0, -1, 4'h1, 32'hA5A5A5A5, 4'h0, 1));
        // requester 1 write, then idle
        tv[5]  = mkv(0, 4'h0, 4'h2, 0, 0,            mke(4'h2, 1, 0,  1, 4'h0, 0, 4'h0, 0));
        tv[6]  = mkv(0, 4'h0, 4'h0, 0, 0,            mke(4'h0, 0, 0, -1, 4'h0, 0, 4'h0, 0));
        // continuous writes from all: rotation continues from pointer 2
        tv[7]  = mkv(0, 4'h0, 4'hF, 0, 0,            mke(4'h4, 1, 0,  2, 4'h0, 0, 4'h0, 0));
        tv[8]  = mkv(0, 4'h0, 4'hF, 0, 0,            mke(4'h8, 1, 0,  3, 4'h0, 0, 4'h0, 0));
        tv[9]  = mkv(0, 4'h0, 4'hF, 0, 0,            mke(4'h1, 1, 0,  0, 4'h0, 0, 4'h0, 0));
        tv[10] = mkv(0, 4'h0, 4'hF, 0, 0,            mke(4'h2, 1, 0,  1, 4'h0, 0, 4'h0, 0));
        // reset, then all-write rotation 0,1,2,3,0
        tv[11] = mkv(1, 4'h0, 4'hF, 0, 0,            mke(4'h0, 0, 0, -1, 4'h0, 0, 4'h0, 0));
        tv[12] = mkv(0, 4'h0, 4'hF, 0, 0,            mke(4'h1, 1, 0,  0, 4'h0, 0, 4'h0, 0));
        tv[13] = mkv(0, 4'h0, 4'hF, 0, 0,            mke(4'h2, 1, 0,  1, 4'h0, 0, 4'h0, 0));
        tv[14] = mkv(0, 4'h0, 4'hF, 0, 0,            mke(4'h4, 1, 0,  2, 4'h0, 0, 4'h0, 0));
        tv[15] = mkv(0, 4'h0, 4'hF, 0, 0,            mke(4'h8, 1, 0,  3, 4'h0, 0, 4'h0, 0));
        tv[16] = mkv(0, 4'h0, 4'hF, 0, 0,            mke(4'h1, 1, 0,  0, 4'h0, 0, 4'h0, 0));
        // requester 2 read with 3-cycle bank latency; requester 0 waits
        tv[17] = mkv(0, 4'h4, 4'h0, 0, 0,            mke(4'h4, 0, 1,  2, 4'h0, 0, 4'h0, 0));
        tv[18] = mkv(0, 4'h1, 4'h0, 0, 0,            mke(4'h0, 0, 0, -1, 4'h0, 0, 4'h0, 1));
        tv[19] = mkv(0, 4'h1, 4'h0, 0, 0,            mke(4'h0, 0, 0, -1, 4'h0, 0, 4'h0, 1));
        tv[20] = mkv(0, 4'h1, 4'h0, 1, 32'h12345678, mke(4'h0, 0, 0, -1, 4'h4, 32'h12345678, 4'h0, 1));
        tv[21] = mkv(0, 4'h1, 4'h0, 0, 0,            mke(4'h1, 0, 1,  0, 4'h0, 0, 4'h0, 0));
        tv[22] = mkv(0, 4'h0, 4'h0, 1, 32'h0BADF00D, mke(4'h0, 0, 0, -1, 4'h1, 32'h0BADF00D, 4'h0, 1));
        // spurious bank_rvalid in IDLE
        tv[23] = mkv(0, 4'h0, 4'h0, 1, 32'h55555555, mke(4'h0, 0, 0, -1, 4'h0, 0, 4'h0, 0));
        // ren+wen together is a write
        tv[24] = mkv(0, 4'h2, 4'h2, 0, 0,            mke(4'h2, 1, 0,  1, 4'h0, 0, 4'h0, 0));
        tv[25] = mkv(0, 4'h0, 4'h0, 0, 0,            mke(4'h0, 0, 0, -1, 4'h0, 0, 4'h0, 0));
        // reset in the middle of a read; late bank_rvalid is dropped
        tv[26] = mkv(0, 4'h8, 4'h0, 0, 0,            mke(4'h8, 0, 1,  3, 4'h0, 0, 4'h0, 0));
        tv[27] = mkv(0, 4'h0, 4'h0, 0, 0,            mke(4'h0, 0, 0, -1, 4'h0, 0, 4'h0, 1));
        tv[28] = mkv(1, 4'h0, 4'h0, 0, 0,            mke(4'h0, 0, 0, -1, 4'h0, 0, 4'h0, 0));
        tv[29] = mkv(0, 4'h0, 4'h0, 1, 32'hFFFF0000, mke(4'h0, 0, 0, -1, 4'h0, 0, 4'h0, 0));
        tv[30] = mkv(0, 4'h2, 4'h0, 0, 0,            mke(4'h2, 0, 1,  1, 4'h0, 0, 4'h0, 0));
        tv[31] = mkv(0, 4'h0, 4'h0, 1, 32'h00000001, mke(4'h0, 0, 0, -1, 4'h2, 32'h00000001, 4'h0, 1));

        drive(1, 4'hF, 4'h0, 0, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++) begin
            cycle($sformatf("v%0d", i), tv[i].r, tv[i].ren, tv[i].wen, tv[i].brv, tv[i].brd, tv[i].e);
        end

        // long read by requester 3 (pointer is 2 here); requester 0 pending throughout
        cycle("lr.gnt", 0, 4'h8, 4'h0, 0, 0, mke(4'h8, 0, 1, 3, 4'h0, 0, 4'h0, 0));
`ifdef SCRATCHPAD_ARB_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            cycle($sformatf("to.wait%0d", i), 0, 4'h1, 4'h0, 0, 0,
                  mke(4'h0, 0, 0, -1, 4'h0, 0, 4'h0, 1));
        end
        cycle("to.fire", 0, 4'h0, 4'h0, 0, 0, mke(4'h0, 0, 0, -1, 4'h8, 32'hDEADBEEF, 4'h8, 1));
        cycle("to.late", 0, 4'h0, 4'h0, 1, 32'h77777777, mke(4'h0, 0, 0, -1, 4'h0, 0, 4'h0, 0));
`else
        for (int i = 0; i < 20; i++) begin
            cycle($sformatf("lw.wait%0d", i), 0, 4'h1, 4'h0, 0, 0,
                  mke(4'h0, 0, 0, -1, 4'h0, 0, 4'h0, 1));
        end
        cycle("lw.done", 0, 4'h0, 4'h0, 1, 32'h0A0B0C0D, mke(4'h0, 0, 0, -1, 4'h8, 32'h0A0B0C0D, 4'h0, 1));
        cycle("lw.idle", 0, 4'h0, 4'h0, 0, 0, mke(4'h0, 0, 0, -1, 4'h0, 0, 4'h0, 0));
`endif

        // randomized traffic against the reference model, starting from reset
        model_step(1, 4'h0, 4'h0, 0, 0, e);
        cycle("rnd.rst", 1, 4'h0, 4'h0, 0, 0, e);
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 39) == 0);
            ren = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            wen = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            brv = ($urandom_range(0, 3) == 0);
            brd = $urandom;
            for (int i = 0; i < NREQ; i++) begin
                cur_addr[i] = 9'($urandom_range(0, 511));
                cur_wd[i]   = $urandom;
            end
            model_step(r, ren, wen, brv, brd, e);
            cycle($sformatf("rnd%0d", n), r, ren, wen, brv, brd, e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
